phase_settle_sequencer: RTL and testbench

- Controls the switch-level NMOS node network: sequences chip clock phases and decides when each phase has settled.
- Each half-cycle: drives pad inputs, then iterates the node solver until node activity stays below a threshold, then samples pad outputs and toggles the chip clock phi.
- Sits between the testbench/host run control and the transistor/node array, which is clocked by eclk.

---
 rtl/phase_settle_sequencer_pkg.sv | 28 ++
 rtl/phase_settle_sequencer_settle_detector.sv | 60 ++++++
 rtl/phase_settle_sequencer.sv | 148 ++++++++++++++
 tb/tb_phase_settle_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_settle_sequencer_pkg.sv
// Shared types and widths for the phase settle sequencer.
// Node value width follows `W (16 unless defined elsewhere).
`ifndef W
`define W 16
`endif

package phase_settle_sequencer_pkg;

    localparam int unsigned NODE_W  = `W;
    localparam int unsigned ITER_W  = 8;
    localparam int unsigned PHASE_W = 32;
    localparam int unsigned QUIET_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        HALT
    } state_e;

    // Combinational verdict for the iteration currently being solved.
    typedef struct packed {
        logic settle;
        logic cap;
    } settle_status_t;

endpackage

// File: rtl/phase_settle_sequencer_settle_detector.sv
// Quiet-run and iteration counters; reports whether the iteration in
// flight settles the phase or reaches the iteration cap.
module phase_settle_sequencer_settle_detector
    import phase_settle_sequencer_pkg::*;
#(
    parameter int unsigned W           = NODE_W,
    parameter int unsigned THRESH      = 2,
    parameter int unsigned QUIET_ITERS = 3,
    parameter int unsigned MAX_ITER    = 64
) (
    input  logic                eclk,
    input  logic                erst_n,
    input  logic                clear_i,
    input  logic                advance_i,
    input  logic [W-1:0]        delta_abs_i,
    output logic [ITER_W-1:0]   iter_count_o,
    output settle_status_t      status_c_o
);

    logic [ITER_W-1:0]  iter_q;
    logic [ITER_W-1:0]  iter_d;
    logic [ITER_W-1:0]  iter_inc;
    logic [QUIET_W-1:0] quiet_q;
    logic [QUIET_W-1:0] quiet_d;
    logic [QUIET_W-1:0] quiet_inc;
    logic               quiet_now;

    // Saturating iteration count and quiet-run length after this iteration.
    always_comb begin
        quiet_now  = (delta_abs_i <= W'(THRESH));
        iter_inc   = (iter_q == ITER_W'(MAX_ITER)) ? iter_q : iter_q + ITER_W'(1);
        quiet_inc  = quiet_now ? quiet_q + QUIET_W'(1) : '0;

        status_c_o.settle = (quiet_inc == QUIET_W'(QUIET_ITERS));
        status_c_o.cap    = (iter_inc == ITER_W'(MAX_ITER));

        iter_d  = iter_q;
        quiet_d = quiet_q;
        if (clear_i) begin
            iter_d  = '0;
            quiet_d = '0;
        end else if (advance_i) begin
            iter_d  = iter_inc;
            quiet_d = quiet_inc;
        end
    end

    always_ff @(posedge eclk or negedge erst_n) begin
        if (!erst_n) begin
            iter_q  <= '0;
            quiet_q <= '0;
        end else begin
            iter_q  <= iter_d;
            quiet_q <= quiet_d;
        end
    end

    assign iter_count_o = iter_q;

endmodule

// File: rtl/phase_settle_sequencer.sv
// Half-cycle sequencer for the switch-level node network: drive pads, iterate
// until node activity is quiet, sample pads, toggle phi. SETTLE_STATS_EN adds max_iter_seen.
module phase_settle_sequencer
    import phase_settle_sequencer_pkg::*;
#(
    parameter int unsigned W               = NODE_W,
    parameter int unsigned THRESH          = 2,
    parameter int unsigned QUIET_ITERS     = 3,
    parameter int unsigned MAX_ITER        = 64,
    parameter int unsigned HALT_ON_TIMEOUT = 0
) (
    input  logic                eclk,
    input  logic                erst_n,
    input  logic                run,
    input  logic                step,
    input  logic [W-1:0]        delta_abs,
    output logic                solver_en,
    output logic                drive_pads,
    output logic                sample_pads,
    output logic                phi,
    output logic                busy,
    output logic                timeout,
    output logic [ITER_W-1:0]   iter_count,
    output logic [PHASE_W-1:0]  phase_count
`ifdef SETTLE_STATS_EN
    ,
    output logic [ITER_W-1:0]   max_iter_seen
`endif
);

    state_e             state_q;
    logic               solver_en_q;
    logic               drive_pads_q;
    logic               sample_pads_q;
    logic               phi_q;
    logic               busy_q;
    logic               timeout_q;
    logic [PHASE_W-1:0] phase_count_q;
    logic [ITER_W-1:0]  iter_count_w;
    settle_status_t     status;

    phase_settle_sequencer_settle_detector #(
        .W           (W),
        .THRESH      (THRESH),
        .QUIET_ITERS (QUIET_ITERS),
        .MAX_ITER    (MAX_ITER)
    ) u_detector (
        .eclk         (eclk),
        .erst_n       (erst_n),
        .clear_i      (state_q == DRIVE),
        .advance_i    (state_q == SETTLE),
        .delta_abs_i  (delta_abs),
        .iter_count_o (iter_count_w),
        .status_c_o   (status)
    );

    // Strobes are registered against the state being entered, so each one
    // is high exactly for the cycle its state is resident.
    always_ff @(posedge eclk or negedge erst_n) begin
        if (!erst_n) begin
            state_q       <= IDLE;
            solver_en_q   <= 1'b0;
            drive_pads_q  <= 1'b0;
            sample_pads_q <= 1'b0;
            phi_q         <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            phase_count_q <= '0;
        end else begin
            solver_en_q   <= 1'b0;
            drive_pads_q  <= 1'b0;
            sample_pads_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (run || step) begin
                        state_q      <= DRIVE;
                        drive_pads_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                DRIVE: begin
                    state_q     <= SETTLE;
                    solver_en_q <= 1'b1;
                end
                SETTLE: begin
                    if (status.settle) begin
                        state_q       <= SAMPLE;
                        sample_pads_q <= 1'b1;
                    end else if (status.cap) begin
                        timeout_q <= 1'b1;
                        if (HALT_ON_TIMEOUT != 0) begin
                            state_q <= HALT;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q       <= SAMPLE;
                            sample_pads_q <= 1'b1;
                        end
                    end else begin
                        solver_en_q <= 1'b1;
                    end
                end
                SAMPLE: begin
                    phi_q         <= ~phi_q;
                    phase_count_q <= phase_count_q + PHASE_W'(1);
                    if (run) begin
                        state_q      <= DRIVE;
                        drive_pads_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SETTLE_STATS_EN
    logic [ITER_W-1:0] max_iter_seen_q;

    // iter_count already holds the finished phase's count while in SAMPLE or HALT.
    always_ff @(posedge eclk or negedge erst_n) begin
        if (!erst_n) begin
            max_iter_seen_q <= '0;
        end else if (((state_q == SAMPLE) || (state_q == HALT)) && (iter_count_w > max_iter_seen_q)) begin
            max_iter_seen_q <= iter_count_w;
        end
    end

    assign max_iter_seen = max_iter_seen_q;
`endif

    assign solver_en   = solver_en_q;
    assign drive_pads  = drive_pads_q;
    assign sample_pads = sample_pads_q;
    assign phi         = phi_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;
    assign iter_count  = iter_count_w;
    assign phase_count = phase_count_q;

endmodule

// File: tb/tb_phase_settle_sequencer.sv
// Self-checking bench: default-parameter instance driven by tables and random
// delta streams, plus a short-cap halting instance for the corner cases.
module tb_phase_settle_sequencer;
    import phase_settle_sequencer_pkg::*;

    localparam int unsigned THRESH = 2;
    localparam int unsigned QUIET  = 3;
    localparam int unsigned MAX_A  = 64;
    localparam int unsigned MAX_B  = 4;
    localparam int unsigned DV_N   = 80;

    typedef struct {
        logic [0:7][15:0] pat;
        int unsigned      len;
        logic [15:0]      fill;
        int unsigned      exp_n;
        bit               exp_to;
    } vec_t;

    logic eclk = 1'b0;
    logic erst_n;

    logic                run_a, step_a;
    logic [NODE_W-1:0]   delta_a;
    logic                solver_en_a, drive_pads_a, sample_pads_a, phi_a, busy_a, timeout_a;
    logic [ITER_W-1:0]   iter_count_a;
    logic [PHASE_W-1:0]  phase_count_a;

    logic                run_b, step_b;
    logic [NODE_W-1:0]   delta_b;
    logic                solver_en_b, drive_pads_b, sample_pads_b, phi_b, busy_b, timeout_b;
    logic [ITER_W-1:0]   iter_count_b;
    logic [PHASE_W-1:0]  phase_count_b;

`ifdef SETTLE_STATS_EN
    logic [ITER_W-1:0]   max_seen_a;
    logic [ITER_W-1:0]   max_seen_b;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_pc;
    bit          exp_to;
    int unsigned exp_max;
    logic [15:0] dvec [DV_N];
    vec_t        vecs [$];

    always #5 eclk = ~eclk;

    phase_settle_sequencer #(
        .W(NODE_W), .THRESH(THRESH), .QUIET_ITERS(QUIET), .MAX_ITER(MAX_A), .HALT_ON_TIMEOUT(0)
    ) dut_a (
        .eclk(eclk), .erst_n(erst_n), .run(run_a), .step(step_a), .delta_abs(delta_a),
        .solver_en(solver_en_a), .drive_pads(drive_pads_a), .sample_pads(sample_pads_a),
        .phi(phi_a), .busy(busy_a), .timeout(timeout_a),
        .iter_count(iter_count_a), .phase_count(phase_count_a)
`ifdef SETTLE_STATS_EN
        , .max_iter_seen(max_seen_a)
`endif
    );

    phase_settle_sequencer #(
        .W(NODE_W), .THRESH(THRESH), .QUIET_ITERS(QUIET), .MAX_ITER(MAX_B), .HALT_ON_TIMEOUT(1)
    ) dut_b (
        .eclk(eclk), .erst_n(erst_n), .run(run_b), .step(step_b), .delta_abs(delta_b),
        .solver_en(solver_en_b), .drive_pads(drive_pads_b), .sample_pads(sample_pads_b),
        .phi(phi_b), .busy(busy_b), .timeout(timeout_b),
        .iter_count(iter_count_b), .phase_count(phase_count_b)
`ifdef SETTLE_STATS_EN
        , .max_iter_seen(max_seen_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: first iteration whose last QUIET deltas are all within THRESH.
    function automatic void model_phase(input int unsigned maxi, output int unsigned n, output bit to);
        bit found;
        bit all_quiet;
        found = 1'b0;
        n     = maxi;
        for (int i = int'(QUIET); i <= int'(maxi) && !found; i++) begin
            all_quiet = 1'b1;
            for (int j = i - int'(QUIET); j < i; j++)
                if (dvec[j] > 16'(THRESH)) all_quiet = 1'b0;
            if (all_quiet) begin
                found = 1'b1;
                n     = int'(i);
            end
        end
        to = !found;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < int'(DV_N); i++)
            dvec[i] = (i < int'(v.len)) ? v.pat[i] : v.fill;
    endtask

    task automatic fill_dvec(input logic [15:0] val);
        for (int i = 0; i < int'(DV_N); i++) dvec[i] = val;
    endtask

    task automatic add_vec(input logic [0:7][15:0] p, input int unsigned len, input logic [15:0] fill,
                           input int unsigned n, input bit to);
        vec_t v;
        v.pat = p; v.len = len; v.fill = fill; v.exp_n = n; v.exp_to = to;
        vecs.push_back(v);
    endtask

    // Entered at the negedge of the DRIVE cycle; returns at the SAMPLE cycle.
    task automatic settle_phase_a(input string name, input int unsigned exp_n);
        int unsigned k;
        int unsigned cyc;
        bit          done;
        k = 0; cyc = 0; done = 1'b0;
        check({name, " drive_pads"}, 32'(drive_pads_a), 32'd1);
        check({name, " busy"}, 32'(busy_a), 32'd1);
        while (!done && cyc < MAX_A + 4) begin
            @(negedge eclk);
            cyc++;
            if (sample_pads_a) done = 1'b1;
            else if (solver_en_a && k < DV_N) begin
                delta_a = dvec[k];
                k++;
            end else begin
                delta_a = NODE_W'($urandom);
            end
        end
        check({name, " sample reached"}, 32'(done), 32'd1);
        check({name, " solver cycles"}, k, exp_n);
        check({name, " iter_count"}, 32'(iter_count_a), exp_n);
        check({name, " timeout"}, 32'(timeout_a), 32'(exp_to));
        check({name, " phase_count pre"}, phase_count_a, exp_pc);
        exp_pc++;
        if (exp_n > exp_max) exp_max = exp_n;
    endtask

    task automatic step_phase_a(input string name, input int unsigned exp_n);
        @(negedge eclk);
        step_a  = 1'b1;
        delta_a = NODE_W'($urandom);
        @(negedge eclk);
        step_a = 1'b0;
        settle_phase_a(name, exp_n);
        @(negedge eclk);
        check({name, " idle busy"}, 32'(busy_a), 32'd0);
        check({name, " idle drive"}, 32'(drive_pads_a), 32'd0);
        check({name, " phase_count"}, phase_count_a, exp_pc);
        check({name, " phi"}, 32'(phi_a), 32'(exp_pc[0]));
`ifdef SETTLE_STATS_EN
        check({name, " max_iter_seen"}, 32'(max_seen_a), exp_max);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "bench time limit");
    end

    initial begin
        int unsigned n;
        bit          to;
        int unsigned pct;

        erst_n = 1'b0;
        run_a = 1'b0; step_a = 1'b0; delta_a = '0;
        run_b = 1'b0; step_b = 1'b0; delta_b = '0;
        exp_pc = 0; exp_to = 1'b0; exp_max = 0;

        add_vec({16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 0, 16'd0, 3, 1'b0);
        add_vec({16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd0, 16'd0, 16'd0}, 5, 16'd0, 8, 1'b0);
        add_vec({16'd0, 16'd0, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 3, 16'd0, 6, 1'b0);
        add_vec({16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 0, 16'd2, 3, 1'b0);
        add_vec({16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1, 16'd0, 4, 1'b0);
        add_vec({16'd0, 16'd0, 16'd3, 16'd1, 16'd2, 16'd2, 16'd0, 16'd0}, 6, 16'd0, 6, 1'b0);
        add_vec({16'd0, 16'd3, 16'd0, 16'd3, 16'd0, 16'd3, 16'd0, 16'd0}, 8, 16'd0, 9, 1'b0);
        add_vec({16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100}, 0, 16'd100, 64, 1'b1);

        #3;
        check("reset solver_en", 32'(solver_en_a), 32'd0);
        check("reset drive_pads", 32'(drive_pads_a), 32'd0);
        check("reset sample_pads", 32'(sample_pads_a), 32'd0);
        check("reset phi", 32'(phi_a), 32'd0);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset timeout", 32'(timeout_a), 32'd0);
        check("reset iter_count", 32'(iter_count_a), 32'd0);
        check("reset phase_count", phase_count_a, 32'd0);
        @(negedge eclk);
        erst_n = 1'b1;

        // Cap of 4: settle on the capping iteration wins, then timeout halts.
        @(negedge eclk); step_b = 1'b1;
        @(negedge eclk); step_b = 1'b0;
        check("b same-edge drive", 32'(drive_pads_b), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge eclk);
            check("b same-edge solver_en", 32'(solver_en_b), 32'd1);
            delta_b = (i == 0) ? NODE_W'(9) : NODE_W'(0);
        end
        @(negedge eclk);
        check("b same-edge sample", 32'(sample_pads_b), 32'd1);
        check("b same-edge iter", 32'(iter_count_b), 32'd4);
        check("b same-edge timeout", 32'(timeout_b), 32'd0);
        @(negedge eclk);
        check("b same-edge phase_count", phase_count_b, 32'd1);
        check("b same-edge phi", 32'(phi_b), 32'd1);
        check("b same-edge idle", 32'(busy_b), 32'd0);

        @(negedge eclk); step_b = 1'b1;
        @(negedge eclk); step_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge eclk);
            delta_b = NODE_W'(100);
        end
        @(negedge eclk);
        check("b halt sample", 32'(sample_pads_b), 32'd0);
        check("b halt solver_en", 32'(solver_en_b), 32'd0);
        check("b halt busy", 32'(busy_b), 32'd0);
        check("b halt timeout", 32'(timeout_b), 32'd1);
        check("b halt iter", 32'(iter_count_b), 32'd4);
        run_b = 1'b1; step_b = 1'b1;
        @(negedge eclk); step_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge eclk);
            check("b halt ignores drive", 32'(drive_pads_b), 32'd0);
            check("b halt ignores busy", 32'(busy_b), 32'd0);
        end
        check("b halt phase_count", phase_count_b, 32'd1);
        run_b = 1'b0;

        // Random delta streams against the window model.
        for (int r = 0; r < 24; r++) begin
            pct = (r % 3 == 0) ? 50 : ((r % 3 == 1) ? 80 : 95);
            for (int i = 0; i < int'(DV_N); i++) begin
                if ($urandom_range(99, 0) < pct) dvec[i] = 16'($urandom_range(THRESH, 0));
                else if ($urandom_range(1, 0) == 0) dvec[i] = 16'(THRESH + 1);
                else dvec[i] = 16'($urandom_range(65535, THRESH + 1));
            end
            model_phase(MAX_A, n, to);
            exp_to = exp_to | to;
            step_phase_a("rand", n);
        end

        foreach (vecs[i]) begin
            load_vec(vecs[i]);
            exp_to = exp_to | vecs[i].exp_to;
            step_phase_a($sformatf("vec%0d", i), vecs[i].exp_n);
        end

        // Free-run: back-to-back phases, run dropped during the second DRIVE.
        load_vec(vecs[1]);
        @(negedge eclk); run_a = 1'b1;
        @(negedge eclk);
        settle_phase_a("run1", 8);
        fill_dvec(16'd0);
        @(negedge eclk);
        run_a = 1'b0;
        settle_phase_a("run2", 3);
        @(negedge eclk);
        check("run end busy", 32'(busy_a), 32'd0);
        check("run end drive", 32'(drive_pads_a), 32'd0);
        check("run end phase_count", phase_count_a, exp_pc);
        check("run end timeout sticky", 32'(timeout_a), 32'd1);

        // Asynchronous reset in the middle of SETTLE.
        @(negedge eclk); step_a = 1'b1;
        @(negedge eclk); step_a = 1'b0;
        @(negedge eclk); delta_a = NODE_W'(100);
        check("mid-reset in settle", 32'(solver_en_a), 32'd1);
        @(negedge eclk);
        #2 erst_n = 1'b0;
        #1;
        check("mid-reset solver_en", 32'(solver_en_a), 32'd0);
        check("mid-reset busy", 32'(busy_a), 32'd0);
        check("mid-reset phi", 32'(phi_a), 32'd0);
        check("mid-reset phase_count", phase_count_a, 32'd0);
        check("mid-reset iter_count", 32'(iter_count_a), 32'd0);
        check("mid-reset timeout", 32'(timeout_a), 32'd0);
        check("mid-reset b timeout", 32'(timeout_b), 32'd0);
        @(negedge eclk);
        erst_n = 1'b1;
        exp_pc = 0; exp_to = 1'b0; exp_max = 0;
        @(negedge eclk);
        check("post-reset drive", 32'(drive_pads_a), 32'd0);
        check("post-reset sample", 32'(sample_pads_a), 32'd0);
        check("post-reset solver_en", 32'(solver_en_a), 32'd0);
        fill_dvec(16'd0);
        step_phase_a("post-reset", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
